// File: rtl/ifp_mem_io.sv
// Host-side serial memory port for one ifp PE chain: shifts a 38-bit record into the
// PE LSB-first and captures the outgoing record in the same pass (SWAP), or recirculates it (READ).
module ifp_mem_io #(
  parameter int REC_W = 38,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [REC_W-1:0] cmd_record,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [REC_W-1:0] rsp_record,
  input  logic             pe_idle,
  output logic             busy,
  output logic             mem_send,
  output logic             mem_receive,
  output logic             pe_data_in,
  input  logic             pe_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_RESP} state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REC_W - 1);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [REC_W-1:0] tx_sr_q, tx_sr_d;
  logic [REC_W-1:0] rx_sr_q, rx_sr_d;
  logic [REC_W-1:0] rsp_rec_q, rsp_rec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             armed_q;
  logic             strobe;

  // armed_q keeps cmd_ready low until the first clock edge after reset release.
  assign cmd_ready   = armed_q & (state_q == S_IDLE) & pe_idle & ~rsp_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign mem_send    = strobe & ~op_q;
  assign mem_receive = strobe &  op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_record  = rsp_rec_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rsp_rec_d   = rsp_rec_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    strobe      = 1'b0;
    pe_data_in  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          tx_sr_d = cmd_record;
          op_d    = cmd_op;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        // Strobe leads data by one cycle because the PE registers it before use.
        strobe  = 1'b1;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        strobe     = (cnt_q != LAST_BIT);
        pe_data_in = op_q ? pe_data_out : tx_sr_q[0];
        rx_sr_d    = {pe_data_out, rx_sr_q[REC_W-1:1]};
        tx_sr_d    = tx_sr_q >> 1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = S_RESP;
      end
      S_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rec_d   = rx_sr_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the shift registers are plain flops, so all of them take the async reset;
  // only true RAM arrays should be left without one.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rsp_rec_q   <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rsp_rec_q   <= rsp_rec_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      armed_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifp_mem_io.sv
// Directed bench for ifp_mem_io with a behavioural PE shift-register model and a
// response scoreboard drained by an independent monitor.
module tb_ifp_mem_io;

  localparam int REC_W = 38;

  logic             clk_i = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_op;
  logic [REC_W-1:0] cmd_record;
  logic             rsp_valid, rsp_ready;
  logic [REC_W-1:0] rsp_record;
  logic             pe_idle, busy, mem_send, mem_receive, pe_data_in, pe_data_out;

  int errors = 0;
  int checks = 0;
  logic [REC_W-1:0] exp_q[$];

  // PE model: strobes registered, then data_in sampled while the registered strobe is high.
  logic [REC_W-1:0] pe_reg;
  logic             send_q, recv_q;
  logic             pe_load;
  logic [REC_W-1:0] pe_load_val;

  always #5 clk_i = ~clk_i;

  ifp_mem_io #(.REC_W(REC_W), .CNT_W(6)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_record  (cmd_record),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_record  (rsp_record),
    .pe_idle     (pe_idle),
    .busy        (busy),
    .mem_send    (mem_send),
    .mem_receive (mem_receive),
    .pe_data_in  (pe_data_in),
    .pe_data_out (pe_data_out)
  );

  assign pe_data_out = pe_reg[0];

  always @(posedge clk_i) begin
    send_q <= mem_send;
    recv_q <= mem_receive;
    if (pe_load)              pe_reg <= pe_load_val;
    else if (send_q | recv_q) pe_reg <= {pe_data_in, pe_reg[REC_W-1:1]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares each response at the handshake against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: actual=%h required=none", rsp_record);
      end else begin
        check("rsp_record", 64'(rsp_record), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic preload(input logic [REC_W-1:0] v);
    @(posedge clk_i); #1;
    pe_load = 1'b1; pe_load_val = v;
    @(posedge clk_i); #1;
    pe_load = 1'b0;
  endtask

  // Presents a command and returns #1 after the accepting edge.
  task automatic issue(input logic op, input logic [REC_W-1:0] rec);
    bit accepted = 0;
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_record = rec;
    while (!accepted && n < 100) begin
      @(negedge clk_i);
      if (cmd_ready) accepted = 1;
      @(posedge clk_i);
      n++;
    end
    #1 cmd_valid = 1'b0;
    if (!accepted) check("accept_timeout", 64'(0), 64'(1));
  endtask

  // Starts #1 after the accepting edge; verifies strobes, serial data, latency, handshake, PE.
  task automatic finish_txn(input logic op, input logic [REC_W-1:0] rec,
                            input logic [REC_W-1:0] exp_rsp, input logic [REC_W-1:0] exp_pe,
                            input int hold);
    logic [40:0] sv, rv, dv, vv;
    logic [40:0] es, ed;
    logic [REC_W-1:0] din_src, r0;
    bit ok;
    int n;
    exp_q.push_back(exp_rsp);
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk_i);
      sv[i] = mem_send; rv[i] = mem_receive; dv[i] = pe_data_in; vv[i] = rsp_valid;
    end
    es      = (41'd1 << 38) - 41'd1;
    din_src = op ? exp_rsp : rec;
    ed      = {2'b00, din_src, 1'b0};
    check("strobe_active", 64'(op ? rv : sv), 64'(es));
    check("strobe_other",  64'(op ? sv : rv), 64'(0));
    check("din_sequence",  64'(dv), 64'(ed));
    check("rsp_latency",   64'(vv), 64'(41'd1 << 40));
    if (hold > 0) begin
      r0 = rsp_record;
      ok = 1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_i); #1 cmd_valid = ~cmd_valid;
        @(negedge clk_i);
        if (rsp_record !== r0 || cmd_ready !== 1'b0 || mem_send !== 1'b0 ||
            mem_receive !== 1'b0 || rsp_valid !== 1'b1) ok = 0;
      end
      @(posedge clk_i); #1 cmd_valid = 1'b0;
      check("backpressure_hold", 64'(ok), 64'(1));
    end
    @(posedge clk_i); #1 rsp_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (rsp_valid && n < 20);
    rsp_ready = 1'b0;
    check("rsp_handshake", 64'({rsp_valid, busy}), 64'(0));
    check("pe_contents", 64'(pe_reg), 64'(exp_pe));
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; pe_idle = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_record = '0;
    rsp_ready = 1'b0; pe_load = 1'b0; pe_load_val = '0;

    // Reset and idle
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", 64'({cmd_ready, rsp_valid, busy, mem_send, mem_receive, pe_data_in}), 64'(0));
    check("reset_rsp_record", 64'(rsp_record), 64'(0));
    @(posedge clk_i); #1 rst_n = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check("ready_after_reset", 64'(cmd_ready), 64'(1));

    // rsp_ready with no response pending
    @(posedge clk_i); #1 rsp_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    check("stray_rsp_ready", 64'({rsp_valid, busy}), 64'(0));
    @(posedge clk_i); #1 rsp_ready = 1'b0;

    // SWAP
    preload(38'h15_0F_00_FF_01);
    issue(1'b0, 38'h2A_5C_3F_81_E7);
    finish_txn(1'b0, 38'h2A_5C_3F_81_E7, 38'h15_0F_00_FF_01, 38'h2A_5C_3F_81_E7, 0);

    // READ is non-destructive
    preload(38'h3_C3_A5_5A_0F);
    issue(1'b1, 38'h0);
    finish_txn(1'b1, 38'h0, 38'h3_C3_A5_5A_0F, 38'h3_C3_A5_5A_0F, 0);

    // Backpressure, then a second SWAP
    preload(38'h0A_BC_DE_12_34);
    issue(1'b0, 38'h11_22_33_44_55);
    finish_txn(1'b0, 38'h11_22_33_44_55, 38'h0A_BC_DE_12_34, 38'h11_22_33_44_55, 10);
    issue(1'b0, 38'h3F_FF_FF_FF_FF);
    finish_txn(1'b0, 38'h3F_FF_FF_FF_FF, 38'h11_22_33_44_55, 38'h3F_FF_FF_FF_FF, 0);

    // pe_idle gating
    @(posedge clk_i); #1;
    pe_idle = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b0; cmd_record = 38'h2_00_00_00_01;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (cmd_ready !== 1'b0 || busy !== 1'b0) ok = 0;
      @(posedge clk_i);
    end
    check("gate_no_accept", 64'(ok), 64'(1));
    #1 pe_idle = 1'b1;
    @(negedge clk_i);
    check("gate_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk_i); #1 cmd_valid = 1'b0;
    finish_txn(1'b0, 38'h2_00_00_00_01, 38'h3F_FF_FF_FF_FF, 38'h2_00_00_00_01, 0);

    // Reset during SHIFT k = 17
    preload(38'h0);
    issue(1'b0, 38'h15_55_55_55_55);
    repeat (19) @(negedge clk_i);
    check("pre_reset_strobe", 64'(mem_send), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("mid_reset_outputs",
             64'({mem_send, mem_receive, busy, rsp_valid, cmd_ready, pe_data_in}), 64'(0));
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    @(posedge clk_i);
    preload(38'h0F_0F_0F_0F_0F);
    issue(1'b0, 38'h2A_5C_3F_81_E7);
    finish_txn(1'b0, 38'h2A_5C_3F_81_E7, 38'h0F_0F_0F_0F_0F, 38'h2A_5C_3F_81_E7, 0);

    repeat (2) @(negedge clk_i);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
